// File: rtl/fifo_write_arbiter_if.sv
// Handshake bundle between N_REQ producers, the write arbiter and the FIFO write port.
// grant_count exists only when FIFO_ARB_GRANT_CNT_EN is defined.
interface fifo_write_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
);
  logic [N_REQ-1:0]         req_valid;
  logic [N_REQ*WIDTH-1:0]   req_data;
  logic [N_REQ-1:0]         req_ready;
  logic                     fifo_full;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic [$clog2(N_REQ)-1:0] grant_id;
  logic                     busy;
`ifdef FIFO_ARB_GRANT_CNT_EN
  logic [N_REQ*16-1:0]      grant_count;

  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_id, busy, grant_count
  );
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy, grant_count
  );
`else
  modport slave (
    input  req_valid, req_data, fifo_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );
  modport master (
    output req_valid, req_data, fifo_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );
`endif
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among N_REQ valid/ready producers.
// Optional per-requester beat counters are enabled by defining FIFO_ARB_GRANT_CNT_EN.
module fifo_write_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input logic                clk,
  input logic                reset,
  fifo_write_arbiter_if.slave bus
);
  localparam int IDW  = $clog2(N_REQ);
  localparam int CNTW = $clog2(MAX_BURST) + 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t           state_reg;
  logic [IDW-1:0]   grant_id_reg;
  logic [CNTW-1:0]  beat_cnt_reg;

  logic [WIDTH-1:0] data_arr [N_REQ];
  logic [N_REQ-1:0] cand;
  logic             cur_valid;
  logic             beat;
  logic             last_beat;
  logic             release_now;
  logic             sel_found;
  logic [IDW-1:0]   sel_id;

  // The current holder is excluded from the candidates while granted, which makes a
  // lone requester at a full-burst release fall back to IDLE for one bubble cycle.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
    assign data_arr[gi]      = bus.req_data[gi*WIDTH +: WIDTH];
    assign cand[gi]          = bus.req_valid[gi] &&
                               !(state_reg == GRANT && grant_id_reg == IDW'(gi));
    assign bus.req_ready[gi] = (state_reg == GRANT) && (grant_id_reg == IDW'(gi)) &&
                               !bus.fifo_full;
  end

  assign cur_valid   = bus.req_valid[grant_id_reg];
  assign beat        = (state_reg == GRANT) && cur_valid && !bus.fifo_full;
  assign last_beat   = beat && (beat_cnt_reg == CNTW'(MAX_BURST - 1));
  assign release_now = (state_reg == GRANT) && (last_beat || !cur_valid);

  // Search upward from grant_id+1 with wrap: indices above the holder first, then the rest.
  always_comb begin
    sel_found = 1'b0;
    sel_id    = grant_id_reg;
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_found && cand[j] && (j > int'(grant_id_reg))) begin
        sel_found = 1'b1;
        sel_id    = IDW'(j);
      end
    end
    for (int j = 0; j < N_REQ; j++) begin
      if (!sel_found && cand[j] && (j <= int'(grant_id_reg))) begin
        sel_found = 1'b1;
        sel_id    = IDW'(j);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      grant_id_reg <= IDW'(N_REQ - 1);
      beat_cnt_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (sel_found) begin
            state_reg    <= GRANT;
            grant_id_reg <= sel_id;
            beat_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (beat) begin
            beat_cnt_reg <= beat_cnt_reg + 1'b1;
          end
          if (release_now) begin
            if (sel_found) begin
              grant_id_reg <= sel_id;
              beat_cnt_reg <= '0;
            end else begin
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.busy          = (state_reg == GRANT);
  assign bus.grant_id      = grant_id_reg;
  assign bus.fifo_write_en = beat;
  assign bus.fifo_data_in  = (state_reg == GRANT) ? data_arr[grant_id_reg] : '0;

`ifdef FIFO_ARB_GRANT_CNT_EN
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_cnt
    logic [15:0] cnt_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        cnt_reg <= '0;
      end else if (beat && grant_id_reg == IDW'(gi) && cnt_reg != 16'hFFFF) begin
        cnt_reg <= cnt_reg + 16'd1;
      end
    end
    assign bus.grant_count[gi*16 +: 16] = cnt_reg;
  end
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Scoreboard bench for fifo_write_arbiter: directed producer streams, expected FIFO
// writes queued at issue time and checked by an independent write monitor.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();
  fifo_write_arbiter #(.N_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    int         gap;
  } exp_t;

  exp_t       exp_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  int         cyc      = 0;
  int         last_cyc = 0;
  int         n_writes = 0;
  logic       stream_mode = 1'b0;
  logic [7:0] mem [N][64];
  int         head [N];
  int         tail [N];
  logic [N-1:0] en;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  // Write monitor: every FIFO write must match the head of the scoreboard, including
  // the cycle distance from the previous write where one is given.
  always @(negedge clk) begin
    if (!reset && bus.fifo_write_en === 1'b1) begin : mon
      exp_t e;
      n_writes++;
      if (!stream_mode) begin
        $display("write src=%0d data=%02h cyc=%0d", bus.grant_id, bus.fifo_data_in, cyc);
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_write: got data 0x%0h, expected no write", bus.fifo_data_in);
        end else begin
          e = exp_q.pop_front();
          check("write_data", 32'(bus.fifo_data_in), 32'(e.data));
          check("write_src", 32'(bus.grant_id), 32'(e.id));
          check("write_ready", 32'(bus.req_ready), 32'(1) << e.id);
          if (e.gap > 0) check("write_gap", 32'(cyc - last_cyc), 32'(e.gap));
        end
      end
      last_cyc = cyc;
    end
  end

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (stream_mode) begin
        bus.req_valid[i]       = (i == 0);
        bus.req_data[i*W +: W] = 8'h00;
      end else begin
        bus.req_valid[i]       = en[i] && (head[i] < tail[i]);
        bus.req_data[i*W +: W] = mem[i][head[i]];
      end
    end
  endtask

  task automatic cycle();
    logic [N-1:0] acc;
    @(negedge clk);
    acc = bus.req_valid & bus.req_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (acc[i]) head[i]++;
    drive();
  endtask

  task automatic load(input int i, input logic [7:0] base, input int n);
    for (int k = 0; k < n; k++) mem[i][tail[i] + k] = base + 8'(k);
    tail[i] += n;
  endtask

  task automatic push(input int id, input logic [7:0] data, input int gap);
    exp_t e;
    e.id   = 2'(id);
    e.data = data;
    e.gap  = gap;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    en            = '0;
    stream_mode   = 1'b0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) begin
      head[i] = 0;
      tail[i] = 0;
    end
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic drain(input int budget);
    int b = 0;
    while (exp_q.size() != 0 && b < budget) begin
      cycle();
      b++;
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d writes outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (4) cycle();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0;
    en            = '0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.fifo_full = 1'b0;
    for (int i = 0; i < N; i++) for (int k = 0; k < 64; k++) mem[i][k] = 8'h00;

    // Reset state
    do_reset();
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_wen", 32'(bus.fifo_write_en), 32'h0);
    check("rst_data", 32'(bus.fifo_data_in), 32'h0);
    check("rst_busy", 32'(bus.busy), 32'h0);
    check("rst_grant", 32'(bus.grant_id), 32'(N - 1));

    // Lone requester: 4 beats, one bubble at the burst boundary, then 2 beats
    load(0, 8'hA0, 6);
    push(0, 8'hA0, 1); push(0, 8'hA1, 1); push(0, 8'hA2, 1);
    push(0, 8'hA3, 1); push(0, 8'hA4, 2); push(0, 8'hA5, 1);
    en = 4'b0001;
    last_cyc = cyc;
    drive();
    drain(30);
    check("t1_grant", 32'(bus.grant_id), 32'h0);
    check("t1_busy", 32'(bus.busy), 32'h0);

    // All requesters streaming: 4-beat bursts in round-robin order, no bubbles
    do_reset();
    for (int i = 0; i < N; i++) load(i, 8'(i * 16), 8);
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < N; i++)
        for (int k = 0; k < MB; k++)
          push(i, 8'(i * 16 + r * 4 + k), 1);
    en = 4'b1111;
    last_cyc = cyc;
    drive();
    drain(60);
`ifdef FIFO_ARB_GRANT_CNT_EN
    for (int i = 0; i < N; i++) check("t2_grant_count", 32'(bus.grant_count[i*16 +: 16]), 32'd8);
`endif

    // Backpressure: full held for 5 cycles after 2 beats from requester 2
    do_reset();
    load(2, 8'h20, 4);
    push(2, 8'h20, 1); push(2, 8'h21, 1); push(2, 8'h22, 6); push(2, 8'h23, 1);
    en = 4'b0100;
    last_cyc = cyc;
    drive();
    repeat (3) cycle();
    bus.fifo_full = 1'b1;
    for (int k = 0; k < 5; k++) begin
      #1;
      check("stall_ready", 32'(bus.req_ready), 32'h0);
      check("stall_wen", 32'(bus.fifo_write_en), 32'h0);
      check("stall_busy", 32'(bus.busy), 32'h1);
      cycle();
    end
    bus.fifo_full = 1'b0;
    drain(20);
    check("t3_beat_cnt", 32'(dut.beat_cnt_reg), 32'(MB));
    check("t3_busy", 32'(bus.busy), 32'h0);

    // Holder drops valid: same-cycle hand-over to requester 3
    do_reset();
    load(1, 8'h10, 4);
    load(3, 8'h30, 4);
    push(1, 8'h10, 1); push(3, 8'h30, 2); push(3, 8'h31, 1);
    push(3, 8'h32, 1); push(3, 8'h33, 1);
    en = 4'b1010;
    last_cyc = cyc;
    drive();
    repeat (2) cycle();
    en[1] = 1'b0;
    drive();
    cycle();
    check("t4_regrant", 32'(bus.grant_id), 32'h3);
    check("t4_busy", 32'(bus.busy), 32'h1);
    drain(20);

    // Reset asserted mid-burst between clock edges
    do_reset();
    load(0, 8'h50, 6);
    push(0, 8'h50, 1); push(0, 8'h51, 1);
    en = 4'b0001;
    last_cyc = cyc;
    w0 = n_writes;
    drive();
    repeat (3) cycle();
    #2 reset = 1'b1;
    #1;
    check("t5_busy", 32'(bus.busy), 32'h0);
    check("t5_ready", 32'(bus.req_ready), 32'h0);
    check("t5_wen", 32'(bus.fifo_write_en), 32'h0);
    check("t5_data", 32'(bus.fifo_data_in), 32'h0);
    check("t5_grant", 32'(bus.grant_id), 32'(N - 1));
    en = '0;
    drive();
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    repeat (4) cycle();
    check("t5_writes", 32'(n_writes - w0), 32'd2);
    check("t5_pending", 32'(exp_q.size()), 32'd0);

`ifdef FIFO_ARB_GRANT_CNT_EN
    // Saturation of requester 0's beat counter
    do_reset();
    stream_mode = 1'b1;
    drive();
    repeat (82100) cycle();
    check("t6_count0", 32'(bus.grant_count[15:0]), 32'hFFFF);
    for (int i = 1; i < N; i++) check("t6_count_other", 32'(bus.grant_count[i*16 +: 16]), 32'h0);
    stream_mode = 1'b0;
    drive();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
